vga_framebuffer_reader: RTL and testbench
=========================================

# vga_framebuffer_reader

Display-side reader of the dual-port pixel RAM that the CPU writes through port A. It generates 640x480@60 Hz VGA timing from the 25 MHz pixel clock and drives port B addresses to fetch the 256x256, 8-bit grayscale image. It returns aligned sync, blank and colour signals to the DAC. It replaces the free-running address counter in the CPU top level and runs in the `vga_clk` domain.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal front porch / sync / back porch
- V_ACTIVE, 480, visible lines
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical front porch / sync / back porch
- X0, 192, first visible column of the image window
- Y0, 112, first visible line of the image window
- RAM_LAT, 1, read latency of RAM port B in clocks; legal values are 1 or 2

Ports:
- clk  in  1  pixel clock (25 MHz, driven by `vga_clk`)
- reset  in  1  asynchronous, active-low reset
- enable  in  1  display enable (the VGA_enable switch AND enable)
- pixel_in  in  8  RAM port B read data (q_b)
- pixel_addr  out  16  RAM port B address
- vga_hsync  out  1  horizontal sync, active low
- vga_vsync  out  1  vertical sync, active low
- vga_blank_n  out  1  high during the active 640x480 area
- vga_sync_n  out  1  composite sync to the DAC; constant 0
- vga_r / vga_g / vga_b  out  8 each  colour; all three equal the pixel value or 0
- frame_start  out  1  one-clock pulse at the start of each frame

## Operation
- h_cnt counts 0..799 and wraps to 0. v_cnt counts 0..524 and increments when h_cnt wraps; v_cnt wraps to 0 after 524.
- Active region: h_cnt < 640 and v_cnt < 480.
- hsync region: h_cnt in 656..751. vsync region: v_cnt in 490..491.
- Image window: h_cnt in X0..X0+255 and v_cnt in Y0..Y0+255.
- Inside the window, pixel_addr = {(v_cnt−Y0)[7:0], (h_cnt−X0)[7:0]}. The address is row-major and uses no multiplier. Outside the window, pixel_addr = 0.
- pixel_addr is a combinational function of the counter registers only.
- enable_frame is a register that samples `enable` only when counters are at (799,524). Enable changes therefore take effect at frame boundaries and never tear a frame.
- When enable_frame = 0:
  - counters and sync keep running, so the monitor stays locked;
  - pixel_addr = 0;
  - colour outputs are 0.
- Colour is pixel_in only when the delayed in-window flag and enable_frame are both 1; otherwise colour is 0.
- frame_start is registered. It is high for exactly the cycle in which the counters equal (0,0) after wrapping from (799,524). It is not asserted for the first frame after reset.
- Reset (asynchronous, any time including mid-line) forces:
  - counters = 0, enable_frame = 0;
  - hsync = 1, vsync = 1, blank_n = 0;
  - rgb = 0, frame_start = 0, delay line cleared.
- The first visible frame after reset is black. Display starts at the next frame boundary where enable is high.

## Timing
- Address-to-data latency is RAM_LAT. The flags for hsync, vsync, active and in-window pass through a delay line of RAM_LAT stages, then one output register.
- All vga_* outputs are registered. They appear RAM_LAT+1 clocks after the counter state that produced them: 2 clocks for RAM_LAT = 1.
- pixel_addr leads the corresponding colour output by exactly RAM_LAT+1 clocks.
- Line = 800 clocks, frame = 420000 clocks. hsync is low for 96 clocks per line; vsync is low for 1600 clocks per frame.
- No handshake with the CPU. Port B is read-only; the block never asserts wren_b.

## Structure
- Shared package `vga_pkg`:
  - timing constants: H_TOTAL = 800, V_TOTAL = 525, sync start/end, window origin;
  - `typedef logic [9:0] vga_cnt_t`;
  - `typedef logic [15:0] pix_addr_t`.
- One sub-module, `vga_timing_gen`:
  - contents: the counters, sync/active decode and frame_start;
  - outputs: h_cnt, v_cnt, hsync_raw, vsync_raw, active_raw.
- The top level holds the address mapping, the RAM_LAT delay line, enable_frame and the output registers.

## Test plan
- Reset released with enable = 1:
  - first hsync falling edge at clock 656+RAM_LAT+1;
  - hsync period is 800 clocks and low width is 96;
  - vsync low for 1600 clocks every 420000 clocks.
- Window corners with the RAM model holding mem[a] = a[7:0]^a[15:8]:
  - at (h,v) = (192,112), pixel_addr = 0x0000;
  - at (447,367), pixel_addr = 0xFFFF;
  - at (191,112) and (448,112), pixel_addr = 0 and colour = 0;
  - colour at (193,113) is 0x01^0x01 = 0x00.
- Latency for RAM_LAT = 1 and for RAM_LAT = 2:
  - stimulus: pixel_in = 0xA5 only for the cycle answering address 0x0305;
  - response: vga_r = vga_g = vga_b = 0xA5 for exactly one cycle, aligned with the delayed window position (197,115).
- Enable toggled mid-frame (low at v = 200):
  - the current frame keeps displaying;
  - the next frame is black;
  - blank_n and sync are unchanged;
  - the frame after enable returns high displays again.
- Reset asserted at h_cnt = 400, v_cnt = 300:
  - outputs go immediately to hsync = 1, vsync = 1, blank_n = 0, rgb = 0;
  - after release, timing restarts from (0,0);
  - no frame_start pulse occurs until 420000 clocks later.
- frame_start counting: exactly one pulse per 420000 clocks over 3 frames, each coinciding with counters at (0,0).

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg: timing defaults, counter/address types and the flag bundle
// shared by the VGA framebuffer reader and its timing generator.
package vga_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  localparam int H_TOTAL =
    H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL =
    V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  localparam int X0_DEF   = 192;
  localparam int Y0_DEF   = 112;
  localparam int WIN_SIZE = 256;

  typedef logic [9:0]  vga_cnt_t;
  typedef logic [15:0] pix_addr_t;

  // Per-pixel flags that travel alongside the RAM read.
  typedef struct packed {
    logic hs_n;
    logic vs_n;
    logic act;
    logic win;
  } vga_flags_t;

  localparam vga_flags_t FLAGS_IDLE = '{
    hs_n: 1'b1,
    vs_n: 1'b1,
    act:  1'b0,
    win:  1'b0
  };

endpackage

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: free-running h/v pixel counters, sync/active decode.
// Ports: clk, reset (async, low) in; h_cnt, v_cnt, hsync_raw, vsync_raw,
// active_raw, frame_end (last pixel) and frame_start (registered) out.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF
) (
  input  logic     clk,
  input  logic     reset,
  output vga_cnt_t h_cnt,
  output vga_cnt_t v_cnt,
  output logic     hsync_raw,
  output logic     vsync_raw,
  output logic     active_raw,
  output logic     frame_end,
  output logic     frame_start
);

  localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam vga_cnt_t H_LAST = vga_cnt_t'(HT - 1);
  localparam vga_cnt_t V_LAST = vga_cnt_t'(VT - 1);
  localparam vga_cnt_t H_VIS  = vga_cnt_t'(H_ACTIVE);
  localparam vga_cnt_t V_VIS  = vga_cnt_t'(V_ACTIVE);
  localparam vga_cnt_t HS0 = vga_cnt_t'(H_ACTIVE + H_FP);
  localparam vga_cnt_t HS1 = vga_cnt_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam vga_cnt_t VS0 = vga_cnt_t'(V_ACTIVE + V_FP);
  localparam vga_cnt_t VS1 = vga_cnt_t'(V_ACTIVE + V_FP + V_SYNC);

  logic h_wrap;
  logic v_wrap;

  assign h_wrap    = (h_cnt == H_LAST);
  assign v_wrap    = (v_cnt == V_LAST);
  assign frame_end = h_wrap && v_wrap;

  // frame_start lands on the same edge that wraps to (0,0), so it is
  // never raised by reset alone.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= frame_end;
      if (h_wrap) begin
        h_cnt <= '0;
        v_cnt <= v_wrap ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

  assign hsync_raw  = !(h_cnt >= HS0 && h_cnt < HS1);
  assign vsync_raw  = !(v_cnt >= VS0 && v_cnt < VS1);
  assign active_raw = (h_cnt < H_VIS) && (v_cnt < V_VIS);

endmodule

// File: rtl/vga_framebuffer_reader.sv
// vga_framebuffer_reader: VGA timing plus port-B address generation for a
// 256x256 8-bit image. Ports: clk, reset (async, low), enable, pixel_in in;
// pixel_addr, vga_hsync/vsync/blank_n/sync_n, vga_r/g/b, frame_start out.
module vga_framebuffer_reader
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter int X0       = X0_DEF,
  parameter int Y0       = Y0_DEF,
  parameter int RAM_LAT  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [7:0]  pixel_in,
  output logic [15:0] pixel_addr,
  output logic        vga_hsync,
  output logic        vga_vsync,
  output logic        vga_blank_n,
  output logic        vga_sync_n,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b,
  output logic        frame_start
);

  localparam vga_cnt_t XS = vga_cnt_t'(X0);
  localparam vga_cnt_t YS = vga_cnt_t'(Y0);

  vga_cnt_t   h_cnt;
  vga_cnt_t   v_cnt;
  logic       hsync_raw;
  logic       vsync_raw;
  logic       active_raw;
  logic       frame_end;
  logic       enable_frame;
  vga_cnt_t   hx;
  vga_cnt_t   vy;
  logic       in_win;
  logic       win_en;
  vga_flags_t cur;
  vga_flags_t dly [RAM_LAT];
  vga_flags_t tail;
  logic [7:0] pix_q;

  vga_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk         (clk),
    .reset       (reset),
    .h_cnt       (h_cnt),
    .v_cnt       (v_cnt),
    .hsync_raw   (hsync_raw),
    .vsync_raw   (vsync_raw),
    .active_raw  (active_raw),
    .frame_end   (frame_end),
    .frame_start (frame_start)
  );

  // Offsets below the origin wrap high, so bits [9:8] clear means
  // the position lies inside the 256-wide span.
  assign hx     = h_cnt - XS;
  assign vy     = v_cnt - YS;
  assign in_win = (h_cnt >= XS) && (hx[9:8] == 2'b00) &&
                  (v_cnt >= YS) && (vy[9:8] == 2'b00);
  assign win_en = in_win && enable_frame;

  assign pixel_addr = win_en ? {vy[7:0], hx[7:0]} : '0;

  // Sampled only on the last pixel so a frame is never torn.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      enable_frame <= 1'b0;
    end else if (frame_end) begin
      enable_frame <= enable;
    end
  end

  assign cur = '{
    hs_n: hsync_raw,
    vs_n: vsync_raw,
    act:  active_raw,
    win:  win_en
  };

  // Flags ride RAM_LAT stages so they meet the RAM data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < RAM_LAT; i++) begin
        dly[i] <= FLAGS_IDLE;
      end
    end else begin
      dly[0] <= cur;
      for (int i = 1; i < RAM_LAT; i++) begin
        dly[i] <= dly[i-1];
      end
    end
  end

  assign tail = dly[RAM_LAT-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vga_hsync   <= 1'b1;
      vga_vsync   <= 1'b1;
      vga_blank_n <= 1'b0;
      pix_q       <= '0;
    end else begin
      vga_hsync   <= tail.hs_n;
      vga_vsync   <= tail.vs_n;
      vga_blank_n <= tail.act;
      pix_q       <= tail.win ? pixel_in : '0;
    end
  end

  assign vga_r      = pix_q;
  assign vga_g      = pix_q;
  assign vga_b      = pix_q;
  assign vga_sync_n = 1'b0;

endmodule

// File: tb/tb_vga_framebuffer_reader.sv
// tb_vga_framebuffer_reader: scoreboard bench for two reader instances
// (RAM_LAT 1 and 2) on a reduced raster, against a position-based model.
module tb_vga_framebuffer_reader;

  localparam int HA = 262;
  localparam int HFP = 2;
  localparam int HS = 4;
  localparam int HB = 2;
  localparam int VA = 8;
  localparam int VFP = 1;
  localparam int VS = 2;
  localparam int VB = 2;
  localparam int X0 = 5;
  localparam int Y0 = 2;
  localparam int HT = HA + HFP + HS + HB;
  localparam int VT = VA + VFP + VS + VB;
  localparam int FRAME = HT * VT;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       bl;
    logic       sn;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } out_t;

  typedef struct packed {
    logic [15:0] a;
    logic        fs;
  } ctl_t;

  localparam out_t RST_OUT = '{
    hs: 1'b1, vs: 1'b1, bl: 1'b0, sn: 1'b0,
    r: 8'h00, g: 8'h00, b: 8'h00
  };

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b1;
  logic inject = 1'b0;

  logic [7:0]  pin [2];
  logic [15:0] addr [2];
  logic        hs [2];
  logic        vs [2];
  logic        bl [2];
  logic        sn [2];
  logic [7:0]  r [2];
  logic [7:0]  g [2];
  logic [7:0]  b [2];
  logic        fs [2];
  logic [7:0]  r2a;

  int n_chk = 0;
  int n_fail = 0;
  int p = 0;
  bit ef = 1'b0;
  bit en_prev = 1'b1;
  int a5cnt [2];

  out_t oq0 [$];
  out_t oq1 [$];
  ctl_t cq [$];

  always #5 clk = ~clk;

  for (genvar i = 0; i < 2; i++) begin : g_dut
    vga_framebuffer_reader #(
      .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HS), .H_BP (HB),
      .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VS), .V_BP (VB),
      .X0 (X0), .Y0 (Y0), .RAM_LAT (i + 1)
    ) u_dut (
      .clk         (clk),
      .reset       (rst_n),
      .enable      (enable),
      .pixel_in    (pin[i]),
      .pixel_addr  (addr[i]),
      .vga_hsync   (hs[i]),
      .vga_vsync   (vs[i]),
      .vga_blank_n (bl[i]),
      .vga_sync_n  (sn[i]),
      .vga_r       (r[i]),
      .vga_g       (g[i]),
      .vga_b       (b[i]),
      .frame_start (fs[i])
    );
  end

  function automatic logic [7:0] ram(input logic [15:0] a,
                                     input logic inj);
    if (inj) return (a == 16'h0305) ? 8'hA5 : 8'h00;
    return a[7:0] ^ a[15:8];
  endfunction

  // RAM port B models: one and two clocks of read latency.
  always @(posedge clk) begin
    pin[0] <= ram(addr[0], inject);
    r2a    <= ram(addr[1], inject);
    pin[1] <= r2a;
  end

  function automatic bit in_win(input int q);
    int h, v;
    h = q % HT;
    v = q / HT;
    return h >= X0 && h < X0 + 256 && v >= Y0 && v < Y0 + 256;
  endfunction

  function automatic logic [15:0] addr_of(input int q, input bit e);
    int h, v;
    h = q % HT;
    v = q / HT;
    if (!(in_win(q) && e)) return 16'h0000;
    return 16'((v - Y0) * 256 + (h - X0));
  endfunction

  function automatic out_t expect_out(input int q, input bit e,
                                      input bit inj);
    out_t o;
    int h, v;
    logic [7:0] px;
    h = q % HT;
    v = q / HT;
    o.hs = !(h >= HA + HFP && h < HA + HFP + HS);
    o.vs = !(v >= VA + VFP && v < VA + VFP + VS);
    o.bl = (h < HA) && (v < VA);
    o.sn = 1'b0;
    px = (in_win(q) && e) ? ram(addr_of(q, e), inj) : 8'h00;
    o.r = px;
    o.g = px;
    o.b = px;
    return o;
  endfunction

  function automatic out_t act_out(input int i);
    out_t o;
    o.hs = hs[i];
    o.vs = vs[i];
    o.bl = bl[i];
    o.sn = sn[i];
    o.r = r[i];
    o.g = g[i];
    o.b = b[i];
    return o;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (pos %0d)",
               nm, act, exp, p % FRAME);
    end
  endtask

  task automatic push_pos();
    oq0.push_back(expect_out(p % FRAME, ef, inject));
    oq1.push_back(expect_out(p % FRAME, ef, inject));
  endtask

  // Reference model: advances one raster position per clock and queues
  // what each instance must show once its pipeline has caught up.
  always @(posedge clk) begin
    #2;
    if (rst_n) begin
      p++;
      if (p % FRAME == 0) ef = en_prev;
      en_prev = enable;
      push_pos();
      cq.push_back('{a: addr_of(p % FRAME, ef),
                     fs: (p % FRAME == 0)});
    end
  end

  // Monitor: compares every presented output against the queue heads.
  always @(negedge clk) begin
    if (rst_n) begin
      if (cq.size() == 0 || oq0.size() == 0 || oq1.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL queue_underflow: got empty expected entry");
      end else begin
        ctl_t c;
        out_t o0, o1;
        c = cq.pop_front();
        o0 = oq0.pop_front();
        o1 = oq1.pop_front();
        chk("addr_lat1", 32'(addr[0]), 32'(c.a));
        chk("addr_lat2", 32'(addr[1]), 32'(c.a));
        chk("fstart_lat1", 32'(fs[0]), 32'(c.fs));
        chk("fstart_lat2", 32'(fs[1]), 32'(c.fs));
        chk("out_lat1", 32'(act_out(0)), 32'(o0));
        chk("out_lat2", 32'(act_out(1)), 32'(o1));
        for (int i = 0; i < 2; i++)
          if (r[i] == 8'hA5) a5cnt[i]++;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Releases reset mid low-phase; the counters then sit at (0,0) until
  // the next edge, and the first RAM_LAT outputs are still reset values.
  task automatic release_reset();
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    oq0.delete();
    oq1.delete();
    cq.delete();
    oq0.push_back(RST_OUT);
    oq1.push_back(RST_OUT);
    oq1.push_back(RST_OUT);
    p = 0;
    ef = 1'b0;
    en_prev = enable;
    push_pos();
  endtask

  // Called at posedge+1, when the counters already hold position p+1.
  task automatic wait_pos(input int target);
    for (int k = 0; k <= FRAME; k++) begin
      if ((p + 1) % FRAME == target) return;
      cyc(1);
    end
    n_chk++;
    n_fail++;
    $display("FAIL wait_pos: got no match expected pos %0d", target);
  endtask

  initial begin
    a5cnt[0] = 0;
    a5cnt[1] = 0;
    pin[0] = 8'h00;
    pin[1] = 8'h00;
    r2a = 8'h00;
    cyc(3);
    release_reset();

    // first frame black, then displays
    cyc(2 * FRAME + int'($urandom_range(0, FRAME / 2)));

    // enable drops mid-frame on line 5
    wait_pos(5 * HT + int'($urandom_range(0, HT - 1)));
    enable = 1'b0;
    cyc(FRAME + FRAME / 2);
    cyc(int'($urandom_range(0, FRAME / 4)));
    enable = 1'b1;
    cyc(FRAME + FRAME / 2);

    // single marked word at address 0x0305
    wait_pos(3);
    a5cnt[0] = 0;
    a5cnt[1] = 0;
    inject = 1'b1;
    cyc(1);
    wait_pos(3);
    inject = 1'b0;
    chk("a5_once_lat1", 32'(a5cnt[0]), 32'd1);
    chk("a5_once_lat2", 32'(a5cnt[1]), 32'd1);

    // asynchronous reset in the middle of a line
    wait_pos(4 * HT + int'($urandom_range(20, HT - 20)));
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_out", 32'(act_out(i)), 32'(RST_OUT));
      chk("rst_addr", 32'(addr[i]), 32'd0);
      chk("rst_fstart", 32'(fs[i]), 32'd0);
    end
    cyc(4);
    release_reset();
    cyc(3 * FRAME + 10);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
